// File: rtl/cycle_sequencer_pkg.sv
// cycle_sequencer_pkg: opcode map, sequencer states and opcode-class helpers shared with the datapath
package cycle_sequencer_pkg;
  localparam logic [5:0] OP_ADD  = 6'd0,  OP_SUB = 6'd1,  OP_AND  = 6'd2,  OP_OR  = 6'd3,
                         OP_XOR  = 6'd4,  OP_NOR = 6'd5,  OP_SLT  = 6'd6,  OP_SLL = 6'd7,
                         OP_SRL  = 6'd8,  OP_SRA = 6'd9,  OP_ADDI = 6'd10, OP_LB  = 6'd11,
                         OP_LH   = 6'd12, OP_LW  = 6'd13, OP_LUI  = 6'd14, OP_MUL = 6'd15,
                         OP_SB   = 6'd16, OP_SH  = 6'd17, OP_SW   = 6'd18, OP_BEQ = 6'd19,
                         OP_BNEQ = 6'd20, OP_BGEZ = 6'd21, OP_J   = 6'd22, OP_JAL = 6'd23,
                         OP_JR   = 6'd24;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT} state_t;
  typedef enum logic [2:0] {C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JUMP, C_JAL, C_BAD} opclass_t;
  function automatic opclass_t op_class(input logic [5:0] op);
    return op > OP_JR                    ? C_BAD    :
           op inside {[OP_LB:OP_LW]}     ? C_LOAD   :
           op inside {[OP_SB:OP_SW]}     ? C_STORE  :
           op inside {[OP_BEQ:OP_BGEZ]}  ? C_BRANCH :
           op == OP_JAL                  ? C_JAL    :
           op inside {OP_J, OP_JR}       ? C_JUMP   : C_ALU;
  endfunction
  function automatic logic [2:0] op_bytes(input logic [5:0] op);
    return op inside {OP_LB, OP_SB} ? 3'd1 : op inside {OP_LH, OP_SH} ? 3'd2 : 3'd4;
  endfunction
endpackage

// File: rtl/cycle_sequencer_opclass.sv
// seq_opclass: combinational opcode-to-class and memory byte-count decoder
module seq_opclass
  import cycle_sequencer_pkg::*;
(
  input  logic [5:0] opcode,
  output opclass_t   cls,
  output logic [2:0] nbytes
);
  assign cls    = op_class(opcode);
  assign nbytes = op_bytes(opcode);
endmodule

// File: rtl/cycle_sequencer.sv
// cycle_sequencer: multi-cycle fetch/decode/exec/mem/wb control FSM with halt, single-step and fault handling
module cycle_sequencer
  import cycle_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        halt_req,
  input  logic        step_mode,
  input  logic [5:0]  opcode,
  input  logic        br_taken,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_src,
  output logic        alu_en,
  output logic        mem_re,
  output logic        mem_we,
  output logic        reg_we,
  output logic        busy,
  output logic        fault,
  output logic [1:0]  byte_idx,
  output logic [15:0] retired
);
  state_t state_q, state_d;
  opclass_t cls;
  logic [2:0] nbytes;
  logic [1:0] idx_q;
  logic [15:0] ret_q;
  logic last_byte, bnd;
  logic ir_c, pcw_c, pcs_c, alu_c, mre_c, mwe_c, rwe_c;
  seq_opclass u_opclass (.opcode(opcode), .cls(cls), .nbytes(nbytes));
  assign last_byte = {1'b0, idx_q} == nbytes - 3'd1;
  always_comb begin
    state_d = state_q;
    bnd = 1'b0;
    ir_c = 1'b0;
    pcw_c = 1'b0;
    pcs_c = 1'b0;
    alu_c = 1'b0;
    mre_c = 1'b0;
    mwe_c = 1'b0;
    rwe_c = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: state_d = start ? S_FETCH : state_q;
      S_FETCH: begin
        ir_c = 1'b1;
        pcw_c = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = cls == C_BAD ? S_FAULT : S_EXEC;
      S_EXEC: begin
        alu_c = 1'b1;
        pcw_c = cls inside {C_JUMP, C_JAL} || (cls == C_BRANCH && br_taken);
        pcs_c = pcw_c;
        state_d = cls inside {C_LOAD, C_STORE} ? S_MEM : S_WB;
        bnd = cls inside {C_BRANCH, C_JUMP};
      end
      S_MEM: begin
        mre_c = cls == C_LOAD;
        mwe_c = cls == C_STORE;
        state_d = last_byte ? S_WB : S_MEM;
        bnd = last_byte && cls == C_STORE;
      end
      S_WB: begin
        rwe_c = 1'b1;
        bnd = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
    endcase
    // halt_req wins over step_mode, but both land in HALT
    if (bnd) state_d = (halt_req || step_mode) ? S_HALT : S_FETCH;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q <= 2'd0;
      ret_q <= 16'd0;
    end else begin
      state_q <= state_d;
      idx_q <= (state_q == S_MEM && !last_byte) ? idx_q + 2'd1 : 2'd0;
      if (bnd) ret_q <= ret_q + 16'd1;
    end
  end
  assign {ir_we, pc_we, pc_src, alu_en, mem_re, mem_we, reg_we} =
    rst ? 7'd0 : {ir_c, pcw_c, pcs_c, alu_c, mre_c, mwe_c, rwe_c};
  assign busy = !rst && state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB};
  assign fault = !rst && state_q == S_FAULT;
  assign byte_idx = (rst || state_q != S_MEM) ? 2'd0 : idx_q;
  assign retired = rst ? 16'd0 : ret_q;
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: begin or resume execution from IDLE or HALT.
REQ-004 SHALL have port halt_req, input, 1 bit: stop at the next instruction boundary.
REQ-005 SHALL have port step_mode, input, 1 bit: when high, execute one instruction per start pulse.
REQ-006 SHALL have port opcode, input, 6 bits: opcode of the latched instruction, valid from DECODE onward.
REQ-007 SHALL have port br_taken, input, 1 bit: branch-compare result from the datapath, sampled in EXEC.
REQ-008 SHALL have outputs ir_we, pc_we, pc_src, alu_en, mem_re, mem_we, reg_we, busy and fault, 1 bit each: datapath enables and status.
REQ-009 SHALL have output byte_idx, 2 bits: byte offset of the current data-memory access.
REQ-010 SHALL have output retired, 16 bits: count of completed instructions.

Function
REQ-011 SHALL implement the states IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT and FAULT.
REQ-012 SHALL leave IDLE for FETCH on start=1 and otherwise hold IDLE.
REQ-013 SHALL in FETCH assert ir_we=1 and pc_we=1 with pc_src=0 (PC+4), and go to DECODE.
REQ-014 SHALL in DECODE go to EXEC for opcode 0..24 and to FAULT for opcode 25..63.
REQ-015 SHALL in EXEC assert alu_en=1 for every opcode.
REQ-016 SHALL in EXEC assert pc_we=1 with pc_src=1 for opcodes 22..24 (j/jal/jr) unconditionally, and for opcodes 19..21 (beq/bneq/bgez) only when br_taken=1.
REQ-017 SHALL route EXEC to the next state by opcode: 11..13 (loads) and 16..18 (stores) to MEM; 0..10, 14, 15 and 23 to WB; 19..22 and 24 to the instruction-boundary decision.
REQ-018 SHALL spend N consecutive MEM cycles, one byte per cycle, with byte_idx counting 0..N-1, where N=1 for lb/sb, 2 for lh/sh and 4 for lw/sw.
REQ-019 SHALL hold mem_re=1 during MEM for loads and mem_we=1 during MEM for stores, and never assert both in the same cycle.
REQ-020 SHALL route the last MEM cycle to WB for loads and to the boundary decision for stores.
REQ-021 SHALL assert reg_we=1 for exactly one cycle in WB, then make the boundary decision.
REQ-022 SHALL at the boundary decision increment retired by 1 (wrapping 0xFFFF to 0x0000), then go to HALT if halt_req=1 or step_mode=1, else to FETCH.
REQ-023 SHALL give halt_req priority over step_mode at the boundary; the result is the same HALT state.
REQ-024 SHALL ignore halt_req asserted mid-instruction unless it is still high at the boundary.
REQ-025 SHALL leave HALT for FETCH on start=1; start is ignored in every state other than IDLE and HALT.
REQ-026 SHALL make FAULT sticky with fault=1, leaving it only on rst, and SHALL not count a faulting instruction in retired.
REQ-027 SHALL drive busy=1 in FETCH, DECODE, EXEC, MEM and WB, and busy=0 in IDLE, HALT and FAULT.
REQ-028 SHALL drive all enables to 0 in states that do not explicitly assert them.
REQ-029 SHALL hold byte_idx at 0 outside MEM.
REQ-030 SHALL give instruction latencies in cycles of: ALU/lui/mul 4; branch/j/jr 3; jal 4; sb 4; sh 5; sw 7; lb 5; lh 6; lw 8.

Reset
REQ-031 SHALL on rst=1 at a clock edge enter IDLE, clear retired and byte_idx to 0, and clear fault.
REQ-032 SHALL drive every output to 0 while rst=1.
REQ-033 SHALL let rst abort any state, including a partially completed MEM burst; the bytes already written are not rolled back.

Structure
REQ-034 SHALL place the opcode constants (0..24), the state encoding, and per-opcode class helpers in a shared package also used by the datapath.
REQ-035 SHALL contain one sub-module, seq_opclass, a combinational opcode-to-class and byte-count decoder.

Verification
REQ-036 SHALL cover: rst, start, opcode=0 (add), step_mode=0 -> FETCH,DECODE,EXEC,WB, reg_we high in cycle 4, retired=1 after 4 cycles.
REQ-037 SHALL cover: opcode=18 (sw) -> four MEM cycles with mem_we=1 and byte_idx 0,1,2,3, reg_we never high, 7-cycle instruction.
REQ-038 SHALL cover: opcode=19 with br_taken=0 then 1 -> pc_we in EXEC only on the second instance, both 3 cycles.
REQ-039 SHALL cover: opcode=40 -> FAULT, fault=1, busy=0, retired unchanged, start ignored, cleared only by rst.
REQ-040 SHALL cover: step_mode=1 with three start pulses -> exactly three instructions retired and HALT after each.
REQ-041 SHALL cover: rst asserted in MEM cycle byte_idx=1 of lw -> IDLE next cycle, all outputs 0, retired=0.
